// File: rtl/fixed_point_pkg.sv
// Shared Q-format constants and operand/result record types for the fixed-point adder.
package fixed_point_pkg;

    localparam int FXP_INT_W  = 8;
    localparam int FXP_FRAC_W = 4;

    typedef struct packed {
        logic [FXP_INT_W-1:0]  int_part;
        logic [FXP_FRAC_W-1:0] frac_part;
    } fxp_operand_t;

    // One extra integer bit absorbs the worst-case carry, so the sum never wraps.
    typedef struct packed {
        logic [FXP_INT_W:0]    int_part;
        logic [FXP_FRAC_W-1:0] frac_part;
    } fxp_result_t;

endpackage

// File: rtl/fixed_point_add_core.sv
// Combinational unsigned fixed-point add: fractional field first, its carry feeds the integer add.
module fixed_point_add_core
    import fixed_point_pkg::*;
#(
    parameter int INT_W  = FXP_INT_W,
    parameter int FRAC_W = FXP_FRAC_W
) (
    input  logic [INT_W-1:0]  a_integer_i,
    input  logic [FRAC_W-1:0] a_fractional_i,
    input  logic [INT_W-1:0]  b_integer_i,
    input  logic [FRAC_W-1:0] b_fractional_i,
    output logic [INT_W:0]    sum_integer_o,
    output logic [FRAC_W-1:0] sum_fractional_o
);

    logic [FRAC_W:0] fsum;
    logic            carry;

    assign fsum             = {1'b0, a_fractional_i} + {1'b0, b_fractional_i};
    assign carry            = fsum[FRAC_W];
    assign sum_fractional_o = fsum[FRAC_W-1:0];
    assign sum_integer_o    = {1'b0, a_integer_i} + {1'b0, b_integer_i}
                            + {{INT_W{1'b0}}, carry};

endmodule

// File: rtl/fixed_point_adder.sv
// Registered Q(INT_W).(FRAC_W) adder with a valid qualifier; results hold while idle.
module fixed_point_adder
    import fixed_point_pkg::*;
#(
    parameter int INT_W  = FXP_INT_W,
    parameter int FRAC_W = FXP_FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [INT_W-1:0]  a_integer,
    input  logic [FRAC_W-1:0] a_fractional,
    input  logic [INT_W-1:0]  b_integer,
    input  logic [FRAC_W-1:0] b_fractional,
    output logic              out_valid,
    output logic [INT_W:0]    result_integer,
    output logic [FRAC_W-1:0] result_fractional
);

    logic [INT_W:0]    sum_integer;
    logic [FRAC_W-1:0] sum_fractional;

    logic              valid_q,      valid_d;
    logic [INT_W:0]    res_int_q,    res_int_d;
    logic [FRAC_W-1:0] res_frac_q,   res_frac_d;

    fixed_point_add_core #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_core (
        .a_integer_i      (a_integer),
        .a_fractional_i   (a_fractional),
        .b_integer_i      (b_integer),
        .b_fractional_i   (b_fractional),
        .sum_integer_o    (sum_integer),
        .sum_fractional_o (sum_fractional)
    );

    // Idle cycles keep the last sum visible; only out_valid reports staleness.
    always_comb begin
        valid_d    = in_valid;
        res_int_d  = res_int_q;
        res_frac_d = res_frac_q;
        if (in_valid) begin
            res_int_d  = sum_integer;
            res_frac_d = sum_fractional;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            res_int_q  <= '0;
            res_frac_q <= '0;
        end else begin
            valid_q    <= valid_d;
            res_int_q  <= res_int_d;
            res_frac_q <= res_frac_d;
        end
    end

    assign out_valid         = valid_q;
    assign result_integer    = res_int_q;
    assign result_fractional = res_frac_q;

endmodule

// File: tb/tb_fixed_point_adder.sv
// Self-checking bench: directed corner cases plus random traffic against an integer-arithmetic model.
module tb_fixed_point_adder;

    localparam int INT_W  = 8;
    localparam int FRAC_W = 4;
    localparam int SCALE  = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [INT_W-1:0]  a_integer, b_integer;
    logic [FRAC_W-1:0] a_fractional, b_fractional;
    logic              out_valid;
    logic [INT_W:0]    result_integer;
    logic [FRAC_W-1:0] result_fractional;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: what the outputs must show after the most recent edge.
    int exp_valid = 0;
    int exp_int   = 0;
    int exp_frac  = 0;

    always #5 clk = ~clk;

    fixed_point_adder #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .a_integer         (a_integer),
        .a_fractional      (a_fractional),
        .b_integer         (b_integer),
        .b_fractional      (b_fractional),
        .out_valid         (out_valid),
        .result_integer    (result_integer),
        .result_fractional (result_fractional)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input bit r, input bit v, input int ai, input int af,
                        input int bi, input int bf, input string tag);
        int total;
        rst          = r;
        in_valid     = v;
        a_integer    = INT_W'(ai);
        a_fractional = FRAC_W'(af);
        b_integer    = INT_W'(bi);
        b_fractional = FRAC_W'(bf);
        @(posedge clk);
        #1;
        total = (ai * SCALE + af) + (bi * SCALE + bf);
        if (r) begin
            exp_valid = 0;
            exp_int   = 0;
            exp_frac  = 0;
        end else if (v) begin
            exp_valid = 1;
            exp_int   = total / SCALE;
            exp_frac  = total % SCALE;
        end else begin
            exp_valid = 0;
        end
        check({tag, ".valid"}, int'(out_valid), exp_valid);
        check({tag, ".int"},   int'(result_integer), exp_int);
        check({tag, ".frac"},  int'(result_fractional), exp_frac);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        a_integer = '0; a_fractional = '0; b_integer = '0; b_fractional = '0;

        step(1, 0, 0, 0, 0, 0, "reset0");
        step(1, 1, 5, 5, 5, 5, "reset1");
        step(0, 0, 0, 0, 0, 0, "post_reset");

        step(0, 1, 2, 5, 1, 10, "basic");
        check("basic.lit_int", int'(result_integer), 3);
        check("basic.lit_frac", int'(result_fractional), 15);

        step(0, 1, 0, 8, 0, 8, "carry_half");
        check("carry_half.lit_int", int'(result_integer), 1);
        step(0, 1, 7, 15, 0, 1, "carry_lsb");
        check("carry_lsb.lit_int", int'(result_integer), 8);

        step(0, 1, 255, 15, 255, 15, "max");
        check("max.lit_int", int'(result_integer), 511);
        check("max.lit_frac", int'(result_fractional), 14);

        step(0, 1, 1, 1, 1, 1, "b2b_0");
        step(0, 1, 3, 3, 4, 4, "b2b_1");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, $urandom_range(255), $urandom_range(15),
                 $urandom_range(255), $urandom_range(15), "idle");
        end
        check("idle.hold_int", int'(result_integer), 7);
        check("idle.hold_frac", int'(result_fractional), 7);

        step(0, 1, 9, 9, 9, 9, "pre_rst");
        step(1, 1, 10, 0, 20, 0, "rst_mid");
        step(0, 0, 0, 0, 0, 0, "after_rst");
        check("after_rst.no30", int'(result_integer), 0);

        step(0, 1, 0, 0, 0, 0, "zero");
        check("zero.lit_valid", int'(out_valid), 1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) == 0), ($urandom_range(3) != 0),
                 $urandom_range(255), $urandom_range(15),
                 $urandom_range(255), $urandom_range(15), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
